uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART link that consumes 8N1 frames on the `rx` line at the baud rate produced by the team's clock-divider settings (`IN_FREQ`/`OUT_FREQ`). It derives an internal 16x oversampling tick, detects and validates the start bit, and samples each data bit at mid-bit. It presents each received byte as a one-cycle valid pulse. It sits between the board RX pin and the command/data consumer logic, mirroring the transmit path that uses the same divider parameters.

## Interface
- `IN_FREQ`, 50000000, system clock frequency in Hz
- `OUT_FREQ`, 9600, baud rate in bits/s
- `OVERSAMPLE`, 16, samples per bit; must be even and ≥ 8
- `clk`  input  1  system clock
- `rst`  input  1  reset; asynchronous, active-low
- `rx`  input  1  serial line; asynchronous to `clk`; idle high
- `data`  output  8  last correctly received byte; holds until the next good byte
- `valid`  output  1  one-cycle pulse when `data` is updated
- `frame_err`  output  1  one-cycle pulse when the stop bit samples low
- `busy`  output  1  high from start-bit detection until the receiver returns to IDLE

## Operation
- **Input synchronizer:** `rx` passes through a 2-FF synchronizer; both flops reset to 1. All logic below uses the synchronized value `rxs`.
- **Tick generator:** `DIV = IN_FREQ/(OUT_FREQ*OVERSAMPLE)`, integer truncation (325 at defaults).
  - Counter runs 0..DIV-1 continuously and is never restarted by frames.
  - `tick` is asserted for one cycle when count = DIV-1.
  - Counter width is `$clog2(DIV)`.
- **Sample counter:** `scnt`, `$clog2(OVERSAMPLE)` bits, advances only on `tick`.
- **Bit counter:** `bcnt`, 3 bits.
- **State machine:**
  - **IDLE:** `busy`=0. On a `tick` with `rxs`=0, go to START with `scnt`=0.
  - **START:** on the tick where `scnt` = OVERSAMPLE/2-1 (mid start bit):
    - `rxs`=1: false start, go to IDLE with no outputs.
    - `rxs`=0: go to DATA with `scnt`=0 and `bcnt`=0.
  - **DATA:** on the tick where `scnt` = OVERSAMPLE-1:
    - Shift `rxs` into the MSB of the shift register, so bits arrive LSB first.
    - If `bcnt`=7, go to STOP; otherwise increment `bcnt`.
    - `scnt` wraps to 0.
  - **STOP:** on the tick where `scnt` = OVERSAMPLE-1:
    - `rxs`=1: load `data` from the shift register, pulse `valid`, go to IDLE.
    - `rxs`=0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
  - **BREAK:** `busy`=1. Go to IDLE on the first `tick` with `rxs`=1. A held-low line (break condition) produces only one `frame_err`.
- `valid` and `frame_err` are mutually exclusive and never asserted together.
- Reset may arrive mid-frame. All state is cleared immediately. The partial byte is discarded and produces no pulse. After reset releases, the receiver resynchronizes on the next falling edge seen in IDLE; if the line is mid-frame, garbage or a `frame_err` may result. This is accepted behaviour.

## Timing
- **Reset values:** `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, tick count 0, synchronizer flops 1.
- **Detection latency:** 2 cycles of synchronizer plus up to DIV cycles of tick granularity after the `rx` falling edge.
- **Sample points:** the first data sample falls OVERSAMPLE/2 + OVERSAMPLE ticks after detection. Each later sample is OVERSAMPLE ticks after the previous one.
- **Output latency:** `valid`/`frame_err` are registered and assert in the cycle after the stop-sample tick. That is (OVERSAMPLE/2 + 9·OVERSAMPLE) ticks after detection: 152 ticks = 49400 clk at defaults.
- **`busy` timing:** `busy` rises in the cycle after detection. It falls in the same cycle `valid` rises, or when BREAK exits.
- **Back-to-back frames:** a new start bit immediately after the stop bit is accepted. IDLE is re-entered by the stop mid-sample, so half a bit of margin remains.
- **Baud tolerance:** ±3% mismatch between transmitter and `OUT_FREQ` must receive correctly.

## Test plan
- **Reset defaults:** hold `rst`=0 for 10 cycles with `rx`=1, then release → all outputs at reset values and `busy` stays 0 for 20000 cycles.
- **Single byte:** send 0xA5 at 9600 baud (5208 clk/bit) → exactly one `valid` pulse, `data`=8'hA5, `frame_err`=0, `busy` falls with `valid`.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with no idle gap → three `valid` pulses with `data` matching in order.
- **Glitch and framing error:**
  - A low glitch of 3·DIV cycles → no `valid`, `busy` returns to 0 before the mid-start point plus 1 tick.
  - A frame 0x55 with stop=0, then `rx` held low for 3 bit times → one `frame_err`, no `valid`, `data` unchanged, `busy` high until `rx` returns high.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0x81 → no pulses; outputs return to reset values immediately. The next clean 0x42 is received correctly.
- **Baud skew:** send 0xC3 at ±3% baud (5052 and 5364 clk/bit) → `data`=8'hC3 with `valid` in both cases.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, free-running 16x oversample tick,
// mid-bit sampling, one-cycle valid / frame_err pulses and a busy flag.
module uart_rx #(
  parameter int IN_FREQ    = 50000000,
  parameter int OUT_FREQ   = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = IN_FREQ / (OUT_FREQ * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t          state_r;
  logic [1:0]      sync_r;
  logic [CW-1:0]   tick_cnt_r;
  logic [SW-1:0]   scnt_r;
  logic [2:0]      bcnt_r;
  logic [7:0]      shift_r;
  logic            rxs_s;
  logic            tick_s;

  assign rxs_s  = sync_r[1];
  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // Free-running oversample tick divider, never realigned to frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= {CW{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {CW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + CW'(1);
    end
  end

  // Receive state machine with registered data, pulses and busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      scnt_r    <= {SW{1'b0}};
      bcnt_r    <= 3'd0;
      shift_r   <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          busy <= 1'b0;
          if (tick_s && !rxs_s) begin
            state_r <= ST_START;
            scnt_r  <= {SW{1'b0}};
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (scnt_r == SCNT_MID) begin
              scnt_r <= {SW{1'b0}};
              bcnt_r <= 3'd0;
              if (rxs_s) begin
                state_r <= ST_IDLE;
                busy    <= 1'b0;
              end else begin
                state_r <= ST_DATA;
              end
            end else begin
              scnt_r <= scnt_r + SW'(1);
            end
          end else begin
            state_r <= ST_START;
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (scnt_r == SCNT_LAST) begin
              scnt_r  <= {SW{1'b0}};
              shift_r <= {rxs_s, shift_r[7:1]};
              if (bcnt_r == 3'd7) begin
                state_r <= ST_STOP;
              end else begin
                bcnt_r <= bcnt_r + 3'd1;
              end
            end else begin
              scnt_r <= scnt_r + SW'(1);
            end
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            if (scnt_r == SCNT_LAST) begin
              scnt_r <= {SW{1'b0}};
              if (rxs_s) begin
                data    <= shift_r;
                valid   <= 1'b1;
                busy    <= 1'b0;
                state_r <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state_r   <= ST_BREAK;
              end
            end else begin
              scnt_r <= scnt_r + SW'(1);
            end
          end else begin
            state_r <= ST_STOP;
          end
        end
        ST_BREAK: begin
          // A held-low line stays here so it reports only one frame_err.
          if (tick_s && rxs_s) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a scaled clock (DIV=6, 96 clk/bit) with a byte scoreboard.
module tb_uart_rx;

  localparam int IN_FREQ    = 96000;
  localparam int OUT_FREQ   = 1000;
  localparam int OVERSAMPLE = 16;
  localparam int DIV        = IN_FREQ / (OUT_FREQ * OVERSAMPLE);
  localparam int BIT        = DIV * OVERSAMPLE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int passed = 0;
  int total  = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  logic busy_seen = 1'b0;
  logic prev_busy = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(.IN_FREQ(IN_FREQ), .OUT_FREQ(OUT_FREQ), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit_clk, input logic stop);
    rx = 1'b0;
    repeat (bit_clk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_clk) @(negedge clk);
    end
    rx = stop;
    repeat (bit_clk) @(negedge clk);
  endtask

  // Output monitor: pops the scoreboard on every valid pulse.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      check("sb_has_entry", {31'd0, (exp_q.size() > 0)}, 32'd1);
      if (exp_q.size() > 0) check("data_on_valid", {24'd0, data}, {24'd0, exp_q.pop_front()});
      check("busy_falls_with_valid", {30'd0, prev_busy, busy}, 32'd2);
      check("valid_ferr_exclusive", {31'd0, frame_err}, 32'd0);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    busy_seen = busy_seen | busy;
    prev_busy = busy;
  end

  initial begin
    int v0;
    int f0;
    #3 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    busy_seen = 1'b0;
    repeat (2000) @(negedge clk);
    check("idle_busy_never", {31'd0, busy_seen}, 32'd0);

    // Single byte
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, BIT, 1'b1);
    repeat (BIT) @(negedge clk);
    check("single_valid_cnt", valid_cnt - v0, 32'd1);
    check("single_ferr_cnt", ferr_cnt - f0, 32'd0);
    check("single_data", {24'd0, data}, 32'hA5);
    check("single_busy_idle", {31'd0, busy}, 32'd0);

    // Back-to-back frames, no idle gap
    v0 = valid_cnt;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
    send_frame(8'h00, BIT, 1'b1);
    send_frame(8'hFF, BIT, 1'b1);
    send_frame(8'h3C, BIT, 1'b1);
    repeat (BIT) @(negedge clk);
    check("b2b_valid_cnt", valid_cnt - v0, 32'd3);
    check("b2b_sb_empty", exp_q.size(), 32'd0);
    check("b2b_data", {24'd0, data}, 32'h3C);

    // Short low glitch: false start
    v0 = valid_cnt; f0 = ferr_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    repeat (2 * BIT) @(negedge clk);
    check("glitch_no_valid", valid_cnt - v0, 32'd0);
    check("glitch_no_ferr", ferr_cnt - f0, 32'd0);

    // Framing error followed by break
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, BIT, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    check("break_busy_high", {31'd0, busy}, 32'd1);
    check("break_ferr_once", ferr_cnt - f0, 32'd1);
    check("break_no_valid", valid_cnt - v0, 32'd0);
    check("break_data_kept", {24'd0, data}, 32'h3C);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break_busy_exit", {31'd0, busy}, 32'd0);
    check("break_ferr_still_once", ferr_cnt - f0, 32'd1);

    // Reset during data bit 4 of 0x81
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0) ? 1'b1 : 1'b0;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_data", {24'd0, data}, 32'h00);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_ferr", {31'd0, frame_err}, 32'd0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("midrst_no_valid", valid_cnt - v0, 32'd0);
    check("midrst_no_ferr", ferr_cnt - f0, 32'd0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, BIT, 1'b1);
    repeat (BIT) @(negedge clk);
    check("after_rst_valid", valid_cnt - v0, 32'd1);
    check("after_rst_data", {24'd0, data}, 32'h42);

    // Baud skew of roughly +/-3%
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, BIT - 3, 1'b1);
    repeat (BIT) @(negedge clk);
    check("fast_valid", valid_cnt - v0, 32'd1);
    check("fast_data", {24'd0, data}, 32'hC3);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, BIT + 3, 1'b1);
    repeat (BIT) @(negedge clk);
    check("slow_valid", valid_cnt - v0, 32'd2);
    check("slow_data", {24'd0, data}, 32'hC3);
    check("skew_no_ferr", ferr_cnt - f0, 32'd0);
    check("final_sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
